// File: rtl/test_mon_pkg.sv
// Shared encodings for the end-of-test PC monitor.
package test_mon_pkg;

    // Verdict / state encoding as seen on status_o.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_HANG    = 3'd5;

    // Watch-slot kinds.
    localparam logic [1:0] WK_OFF   = 2'b00;
    localparam logic [1:0] WK_PASS  = 2'b01;
    localparam logic [1:0] WK_FAIL  = 2'b10;
    localparam logic [1:0] WK_CHECK = 2'b11;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StRun     = ST_RUN,
        StPass    = ST_PASS,
        StFail    = ST_FAIL,
        StTimeout = ST_TIMEOUT,
        StHang    = ST_HANG
    } mon_state_e;

    // Width of a slot index; never narrower than one bit.
    function automatic int unsigned slot_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pc_test_monitor_if.sv
// Fetch-stream bundle observed by the monitor: current PC and fetch-accept strobe.
interface pc_test_monitor_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [ADDR_W-1:0] pc_i;
    logic              fetch_i;

    modport master (output pc_i, output fetch_i);
    modport slave  (input  pc_i, input  fetch_i);
endinterface

// File: rtl/test_mon_match.sv
// Combinational priority matcher: lowest-index enabled slot whose address equals the PC.
module test_mon_match
    import test_mon_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_WATCH = 4,
    parameter int unsigned SLOT_W    = slot_width(NUM_WATCH)
) (
    input  logic [ADDR_W-1:0]           pc_i,
    input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr_i,
    input  logic [NUM_WATCH*2-1:0]      watch_kind_i,
    output logic                        hit_o,
    output logic [SLOT_W-1:0]           slot_o,
    output logic [1:0]                  kind_o
);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit_o  = 1'b0;
        slot_o = '0;
        kind_o = WK_OFF;
        for (int k = NUM_WATCH - 1; k >= 0; k--) begin
            if (watch_kind_i[2*k +: 2] != WK_OFF &&
                watch_addr_i[k*ADDR_W +: ADDR_W] == pc_i) begin
                hit_o  = 1'b1;
                slot_o = SLOT_W'(k);
                kind_o = watch_kind_i[2*k +: 2];
            end
        end
    end

endmodule

// File: rtl/pc_test_monitor.sv
// End-of-test monitor: watches the fetch PC stream and latches a single verdict.
module pc_test_monitor
    import test_mon_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_WATCH  = 4,
    parameter int unsigned CYCLE_W    = 32,
    parameter int unsigned TIMEOUT    = 2000,
    parameter int unsigned HANG_LIMIT = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable_i,
    pc_test_monitor_if.slave                    fetch_io,
    input  logic [NUM_WATCH*ADDR_W-1:0]         watch_addr_i,
    input  logic [NUM_WATCH*2-1:0]              watch_kind_i,
    input  logic [31:0]                         chk_value_i,
    input  logic [31:0]                         chk_expect_i,
    output logic                                done_o,
    output logic [2:0]                          status_o,
    output logic [CYCLE_W-1:0]                  cycles_o,
    output logic [CYCLE_W-1:0]                  fetches_o,
    output logic [ADDR_W-1:0]                   end_pc_o,
    output logic [slot_width(NUM_WATCH)-1:0]    hit_slot_o
);

    localparam int unsigned SLOT_W = slot_width(NUM_WATCH);
    // Compare values are only consulted when the matching limit is non-zero.
    localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = CYCLE_W'(TIMEOUT - 1);
    localparam logic [CYCLE_W-1:0] HANG_LAST    = CYCLE_W'(HANG_LIMIT - 1);

    mon_state_e          state_q, state_d;
    logic                done_q, done_d;
    logic [CYCLE_W-1:0]  cycles_q, cycles_d;
    logic [CYCLE_W-1:0]  fetches_q, fetches_d;
    logic [CYCLE_W-1:0]  same_cnt_q, same_cnt_d;
    logic [ADDR_W-1:0]   last_pc_q, last_pc_d;
    logic [ADDR_W-1:0]   end_pc_q, end_pc_d;
    logic [SLOT_W-1:0]   hit_slot_q, hit_slot_d;

    logic [ADDR_W-1:0]   pc;
    logic                fetch;
    logic                pc_changed;
    logic                match_hit;
    logic [SLOT_W-1:0]   match_slot;
    logic [1:0]          match_kind;
    mon_state_e          hit_state;
    logic                hang_now;
    logic                timeout_now;

    assign pc    = fetch_io.pc_i;
    assign fetch = fetch_io.fetch_i;

    // last_pc_q is held at 0 in IDLE, so the first RUN cycle is a change iff pc != 0.
    assign pc_changed = (pc != last_pc_q);

    test_mon_match #(
        .ADDR_W    (ADDR_W),
        .NUM_WATCH (NUM_WATCH),
        .SLOT_W    (SLOT_W)
    ) u_match (
        .pc_i         (pc),
        .watch_addr_i (watch_addr_i),
        .watch_kind_i (watch_kind_i),
        .hit_o        (match_hit),
        .slot_o       (match_slot),
        .kind_o       (match_kind)
    );

    // Verdict implied by the winning slot's kind.
    always_comb begin
        hit_state = StFail;
        case (match_kind)
            WK_PASS:  hit_state = StPass;
            WK_FAIL:  hit_state = StFail;
            WK_CHECK: hit_state = (chk_value_i == chk_expect_i) ? StPass : StFail;
            default:  hit_state = StFail;
        endcase
    end

    assign hang_now    = (HANG_LIMIT != 0) && !pc_changed && (same_cnt_q == HANG_LAST);
    assign timeout_now = (TIMEOUT != 0) && (cycles_q == TIMEOUT_LAST);

    // Next-state: FSM, counters and verdict capture.
    always_comb begin
        state_d    = state_q;
        cycles_d   = cycles_q;
        fetches_d  = fetches_q;
        same_cnt_d = same_cnt_q;
        last_pc_d  = last_pc_q;
        end_pc_d   = end_pc_q;
        hit_slot_d = hit_slot_q;

        case (state_q)
            StIdle: begin
                cycles_d   = '0;
                fetches_d  = '0;
                same_cnt_d = '0;
                last_pc_d  = '0;
                if (enable_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                last_pc_d = pc;
                if (pc_changed) begin
                    same_cnt_d = '0;
                end else if (same_cnt_q != '1) begin
                    same_cnt_d = same_cnt_q + CYCLE_W'(1);
                end
                // The terminal-entry cycle is still a RUN cycle and is counted.
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + CYCLE_W'(1);
                end
                if (fetch && fetches_q != '1) begin
                    fetches_d = fetches_q + CYCLE_W'(1);
                end
                if (pc_changed && match_hit) begin
                    state_d    = hit_state;
                    end_pc_d   = pc;
                    hit_slot_d = match_slot;
                end else if (hang_now) begin
                    state_d    = StHang;
                    end_pc_d   = pc;
                    hit_slot_d = '0;
                end else if (timeout_now) begin
                    state_d    = StTimeout;
                    end_pc_d   = pc;
                    hit_slot_d = '0;
                end
            end
            default: begin
                // Terminal verdicts hold until reset.
            end
        endcase

        done_d = (state_d != StIdle) && (state_d != StRun);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            cycles_q   <= '0;
            fetches_q  <= '0;
            same_cnt_q <= '0;
            last_pc_q  <= '0;
            end_pc_q   <= '0;
            hit_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            cycles_q   <= cycles_d;
            fetches_q  <= fetches_d;
            same_cnt_q <= same_cnt_d;
            last_pc_q  <= last_pc_d;
            end_pc_q   <= end_pc_d;
            hit_slot_q <= hit_slot_d;
        end
    end

    assign done_o     = done_q;
    assign status_o   = state_q;
    assign cycles_o   = cycles_q;
    assign fetches_o  = fetches_q;
    assign end_pc_o   = end_pc_q;
    assign hit_slot_o = hit_slot_q;

endmodule
